// File: rtl/dtw_ctrl_if.sv
// Reference-sample stream into the DTW controller (valid/ready handshake).
interface dtw_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dtw_ctrl.sv
// Sequencer for a systolic DTW array: clears, feeds, drains and tracks the best column.
// Optional threshold match output is built when DTW_THRESH_EN is defined.
module dtw_ctrl #(
    parameter int WIDTH = 16,
    parameter int NPE   = 64,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] ref_len,
    dtw_ctrl_if.slave        s,
    output logic [WIDTH-1:0] pe_y,
    output logic             pe_running,
    output logic             pe_clr,
    input  logic [WIDTH-1:0] last_dtw,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] score,
    output logic [CNT_W-1:0] score_pos
`ifdef DTW_THRESH_EN
    ,
    input  logic [WIDTH-1:0] threshold,
    output logic             match
`endif
);
    localparam int DC_W       = $clog2(NPE + 1) + 1;
    localparam int DRAIN_LAST = (NPE > 1) ? NPE - 2 : 0;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t           state;
    logic             draining;
    logic [CNT_W-1:0] len, fc, rc, pos;
    logic [DC_W-1:0]  dc;
    logic [WIDTH-1:0] best;
`ifdef DTW_THRESH_EN
    logic [WIDTH-1:0] thr;
`endif

    // s_ready is registered and high exactly in FEED, so it doubles as the FEED flag.
    assign pe_running = (s.s_ready & s.s_valid) | draining;
    assign pe_y       = s.s_ready ? s.s_data : '0;

    logic             col_vld, better;
    logic [WIDTH-1:0] best_nxt;
    logic [CNT_W-1:0] pos_nxt;

    // The column leaving PE NPE-1 this cycle; folding it in combinationally lets
    // the final column land in score on the same edge that enters DONE.
    always_comb begin
        col_vld  = pe_running && (rc >= CNT_W'(NPE - 1));
        better   = col_vld && (last_dtw < best);
        best_nxt = better ? last_dtw : best;
        pos_nxt  = better ? rc - CNT_W'(NPE - 1) : pos;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s.s_ready <= 1'b0;
            draining  <= 1'b0;
            pe_clr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            score     <= '0;
            score_pos <= '0;
            len       <= '0;
            fc        <= '0;
            rc        <= '0;
            dc        <= '0;
            pos       <= '0;
            best      <= '1;
`ifdef DTW_THRESH_EN
            thr       <= '0;
            match     <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            pe_clr <= 1'b0;
            best   <= best_nxt;
            pos    <= pos_nxt;
            if (pe_running) rc <= rc + 1'b1;
            case (state)
                IDLE: if (start) begin
                    len  <= ref_len;
                    busy <= 1'b1;
`ifdef DTW_THRESH_EN
                    thr  <= threshold;
`endif
                    if (ref_len == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        best      <= '1;
                        pos       <= '0;
                        score     <= '1;
                        score_pos <= '0;
`ifdef DTW_THRESH_EN
                        match     <= ('1 <= threshold);
`endif
                    end else begin
                        state  <= CLEAR;
                        pe_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    s.s_ready <= 1'b1;
                    best      <= '1;
                    pos       <= '0;
                    fc        <= '0;
                    rc        <= '0;
                    dc        <= '0;
                end
                FEED: if (s.s_valid) begin
                    fc <= fc + 1'b1;
                    if (fc + 1'b1 == len) begin
                        s.s_ready <= 1'b0;
                        if (NPE == 1) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            score     <= best_nxt;
                            score_pos <= pos_nxt;
`ifdef DTW_THRESH_EN
                            match     <= (best_nxt <= thr);
`endif
                        end else begin
                            state    <= DRAIN;
                            draining <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    dc <= dc + 1'b1;
                    if (dc == DC_W'(DRAIN_LAST)) begin
                        state     <= DONE;
                        draining  <= 1'b0;
                        done      <= 1'b1;
                        score     <= best_nxt;
                        score_pos <= pos_nxt;
`ifdef DTW_THRESH_EN
                        match     <= (best_nxt <= thr);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dtw_ctrl.sv
// Directed bench for dtw_ctrl with NPE=4, WIDTH=16; the PE array is replaced by a cost generator.
module tb_dtw_ctrl;
    localparam int WIDTH = 16;
    localparam int NPE   = 4;
    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] ref_len = '0;
    logic [WIDTH-1:0] pe_y, last_dtw, score;
    logic             pe_running, pe_clr, busy, done;
    logic [CNT_W-1:0] score_pos;
`ifdef DTW_THRESH_EN
    logic [WIDTH-1:0] threshold = '0;
    logic             match;
`endif

    dtw_ctrl_if #(.WIDTH(WIDTH)) sif ();

    dtw_ctrl #(.WIDTH(WIDTH), .NPE(NPE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_len(ref_len), .s(sif.slave),
        .pe_y(pe_y), .pe_running(pe_running), .pe_clr(pe_clr), .last_dtw(last_dtw),
        .busy(busy), .done(done), .score(score), .score_pos(score_pos)
`ifdef DTW_THRESH_EN
        , .threshold(threshold), .match(match)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Stand-in array: counts advances itself and produces a cost per advance/column.
    int          mode = 0;
    logic [15:0] cval = 16'd0;
    int          tb_rc = 0;
    always @(posedge clk)
        if (pe_clr) tb_rc <= 0;
        else if (pe_running) tb_rc <= tb_rc + 1;

    always_comb begin
        last_dtw = 16'd20;
        case (mode)
            0: last_dtw = 16'(100 - (tb_rc + 1));
            1: last_dtw = (tb_rc == 4 || tb_rc == 6) ? 16'd7 : 16'd20;
            default: last_dtw = cval;
        endcase
    end

    int lat, nready, nrun, nclr, merr;

    task automatic run(input logic [CNT_W-1:0] len, input bit stall, input bit hold_start);
        lat = -1; nready = 0; nrun = 0; nclr = 0; merr = 0;
        @(negedge clk);
        start = 1'b1; ref_len = len; sif.s_valid = 1'b0;
        for (int c = 1; c <= 200 && lat < 0; c++) begin
            @(negedge clk);
            if (hold_start) ref_len = 20'd9;
            else start = 1'b0;
            sif.s_valid = stall ? (c % 2 == 0) : 1'b1;
            sif.s_data  = 16'(c);
            #1;
            if (pe_clr) nclr++;
            if (sif.s_ready) nready++;
            if (pe_running) nrun++;
            if (sif.s_ready && (pe_running !== sif.s_valid)) merr++;
            if (sif.s_ready && pe_running && (pe_y !== sif.s_data)) merr++;
            if (done) begin lat = c; start = 1'b0; end
        end
        sif.s_valid = 1'b0;
        start = 1'b0;
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pe_clr", 32'(pe_clr), 32'd0);
        chk("rst_pe_running", 32'(pe_running), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_score_pos", 32'(score_pos), 32'd0);
        rst = 1'b0;

        // Basic run: falling cost, best at last column.
        mode = 0;
        run(20'd6, 1'b0, 1'b0);
        chk("base_latency", 32'(lat), 32'd11);
        chk("base_ready_cycles", 32'(nready), 32'd6);
        chk("base_run_cycles", 32'(nrun), 32'd9);
        chk("base_clr_pulses", 32'(nclr), 32'd1);
        chk("base_score", 32'(score), 32'd91);
        chk("base_pos", 32'(score_pos), 32'd5);
        chk("base_busy_in_done", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("hold_score", 32'(score), 32'd91);
        chk("hold_done_low", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Stalled feed with start held high throughout (must be ignored).
        run(20'd6, 1'b1, 1'b1);
        chk("stall_latency", 32'(lat), 32'd16);
        chk("stall_ready_cycles", 32'(nready), 32'd11);
        chk("stall_mirror", 32'(merr), 32'd0);
        chk("stall_score", 32'(score), 32'd91);
        chk("stall_pos", 32'(score_pos), 32'd5);

        // Empty reference.
        run(20'd0, 1'b0, 1'b0);
        chk("zero_latency", 32'(lat), 32'd1);
        chk("zero_score", 32'(score), 32'hFFFF);
        chk("zero_pos", 32'(score_pos), 32'd0);
        chk("zero_run_cycles", 32'(nrun), 32'd0);
        chk("zero_clr_pulses", 32'(nclr), 32'd0);

        // Tie: equal minima at columns 1 and 3, earlier wins.
        mode = 1;
        run(20'd6, 1'b0, 1'b0);
        chk("tie_score", 32'(score), 32'd7);
        chk("tie_pos", 32'(score_pos), 32'd1);

        // Reference shorter than the array: columns 0,1 cost 96,95.
        mode = 0;
        run(20'd2, 1'b0, 1'b0);
        chk("short_latency", 32'(lat), 32'd7);
        chk("short_score", 32'(score), 32'd95);
        chk("short_pos", 32'(score_pos), 32'd1);

        // Reset in the middle of FEED after three samples.
        @(negedge clk);
        start = 1'b1; ref_len = 20'd6;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            sif.s_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        sif.s_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_score", 32'(score), 32'd0);
        rst = 1'b0;
        run(20'd6, 1'b0, 1'b0);
        chk("restart_clr_pulses", 32'(nclr), 32'd1);
        chk("restart_latency", 32'(lat), 32'd11);
        chk("restart_score", 32'(score), 32'd91);
        chk("restart_pos", 32'(score_pos), 32'd5);

`ifdef DTW_THRESH_EN
        mode = 2;
        threshold = 16'd50;
        cval = 16'd49;
        run(20'd6, 1'b0, 1'b0);
        chk("thr_score_49", 32'(score), 32'd49);
        chk("thr_match_49", 32'(match), 32'd1);
        cval = 16'd51;
        run(20'd6, 1'b0, 1'b0);
        chk("thr_score_51", 32'(score), 32'd51);
        chk("thr_match_51", 32'(match), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
